// File: rtl/xbar_pkg.sv
// Shared crossbar definitions used by the slave endpoints: command encoding,
// out-of-range read pattern and the slave FSM state type.
package xbar_pkg;

    localparam logic        CMD_RD    = 1'b0;
    localparam logic        CMD_WR    = 1'b1;
    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK_WAIT = 2'd1,
        RD_WAIT  = 2'd2
    } slv_state_t;

endpackage

// File: rtl/slave_mem_array.sv
// Single-port DEPTH x 32 synchronous storage with a registered, read-enabled
// output. Only the read register is reset; the array contents survive reset.
module slave_mem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/slave_mem_endpoint.sv
// Word-addressed memory slave with programmable ack and read-response latency.
// Define SLAVE_MEM_PROTO_CHK_EN to enable the sticky err flag for req-while-busy.
//
// state    | meaning
// IDLE     | waiting for req; req latches cmd/addr/wdata
// ACK_WAIT | counting down to the ack; writes commit on the ack edge
// RD_WAIT  | read acked, counting down to resp with rdata
module slave_mem_endpoint
    import xbar_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DEPTH   = 256,
    parameter int ACK_LAT = 1,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic              resp,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LAT_MAX = (ACK_LAT > RD_LAT) ? ACK_LAT : RD_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    slv_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic             oor_q;
    logic             rd_oor_q;
    logic             cnt_done;
    logic             mem_we;
    logic             mem_re;
    logic [31:0]      arr_rdata;

    assign cnt_done = (cnt == '0);

    // Gated with rst so an aborted transaction never touches the array.
    assign mem_we = rst && (state == ACK_WAIT) && cnt_done && (cmd_q == CMD_WR) && !oor_q;
    assign mem_re = rst && (state == RD_WAIT) && cnt_done && !oor_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ack      <= 1'b0;
            resp     <= 1'b0;
            cmd_q    <= CMD_RD;
            idx_q    <= '0;
            wdata_q  <= '0;
            oor_q    <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            ack  <= 1'b0;
            resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cmd_q   <= cmd;
                        idx_q   <= addr[IDX_W-1:0];
                        wdata_q <= wdata;
                        oor_q   <= |(addr >> IDX_W);
                        cnt     <= CNT_W'(ACK_LAT - 1);
                        state   <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (cnt_done) begin
                        ack <= 1'b1;
                        if (cmd_q == CMD_WR) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= CNT_W'(RD_LAT - 1);
                            state <= RD_WAIT;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (cnt_done) begin
                        resp     <= 1'b1;
                        rd_oor_q <= oor_q;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    slave_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Both sources only move on a resp edge or reset, so rdata holds between reads.
    assign rdata = rd_oor_q ? OOR_RDATA : arr_rdata;

`ifdef SLAVE_MEM_PROTO_CHK_EN
    logic       viol;
    logic       err_q;
    logic [7:0] viol_cnt;

    assign viol = req && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q    <= 1'b0;
            viol_cnt <= '0;
        end else if (viol) begin
            err_q <= 1'b1;
            if (viol_cnt != 8'hFF) begin
                viol_cnt <= viol_cnt + 8'd1;
            end
        end
    end

    assign err = err_q;

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (!rst) !viol)
        else $warning("slave_mem_endpoint: req while busy ignored");
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_slave_mem_endpoint.sv
// Bench for slave_mem_endpoint: default-latency instance (a) and a 3/4-latency
// instance (b) checked against a transaction-level memory model.
module tb_slave_mem_endpoint;

    localparam logic [31:0] OOR_VAL = 32'hDEAD_BEEF;
`ifdef SLAVE_MEM_PROTO_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        cmd = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack_a, resp_a, err_a, ack_b, resp_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [2][256];
    bit          wr_m  [2][256];

    always #5 clk = ~clk;

    slave_mem_endpoint dut_a (
        .clk(clk), .rst(rst), .req(req_a), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack_a), .resp(resp_a), .rdata(rdata_a), .err(err_a)
    );

    slave_mem_endpoint #(.ACK_LAT(3), .RD_LAT(4)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack_b), .resp(resp_b), .rdata(rdata_b), .err(err_b)
    );

    function automatic logic [31:0] exp_read(input bit b, input logic [29:0] a);
        if ((a >> 8) != 0) return OOR_VAL;
        return mem_m[b][a[7:0]];
    endfunction

    function automatic void model_write(input bit b, input logic [29:0] a, input logic [31:0] d);
        if ((a >> 8) == 0) begin
            mem_m[b][a[7:0]] = d;
            wr_m[b][a[7:0]]  = 1'b1;
        end
    endfunction

    task automatic do_txn(input bit b, input bit c, input logic [29:0] a, input logic [31:0] d);
        int la, lr, n_ack, n_resp, ack_at, resp_at;
        logic [31:0] exp_d, got_d;
        la = b ? 3 : 1;
        lr = b ? 4 : 2;
        exp_d = exp_read(b, a);
        n_ack = 0; n_resp = 0; ack_at = -1; resp_at = -1; got_d = '0;
        @(negedge clk);
        cmd = c; addr = a; wdata = d;
        if (b) req_b = 1'b1; else req_a = 1'b1;
        for (int k = 0; k < la + lr + 4; k++) begin
            @(negedge clk);
            req_a = 1'b0; req_b = 1'b0;
            if (b ? ack_b : ack_a) begin n_ack++; ack_at = k; end
            if (b ? resp_b : resp_a) begin n_resp++; resp_at = k; got_d = b ? rdata_b : rdata_a; end
        end
        n_checks++;
        if (n_ack !== 1 || ack_at !== la) begin
            n_fail++;
            $display("FAIL ack_timing dut%0d cmd=%0d addr=%h: got %0d acks last at %0d, want 1 at %0d",
                     b, c, a, n_ack, ack_at, la);
        end
        if (c) begin
            n_checks++;
            if (n_resp !== 0) begin
                n_fail++;
                $display("FAIL write_no_resp dut%0d addr=%h: got %0d resps, want 0", b, a, n_resp);
            end
            model_write(b, a, d);
        end else begin
            n_checks++;
            if (n_resp !== 1 || resp_at !== la + lr) begin
                n_fail++;
                $display("FAIL resp_timing dut%0d addr=%h: got %0d resps last at %0d, want 1 at %0d",
                         b, a, n_resp, resp_at, la + lr);
            end
            n_checks++;
            if (got_d !== exp_d) begin
                n_fail++;
                $display("FAIL rdata dut%0d addr=%h: got %h want %h", b, a, got_d, exp_d);
            end
            n_checks++;
            if ((b ? rdata_b : rdata_a) !== exp_d) begin
                n_fail++;
                $display("FAIL rdata_hold dut%0d addr=%h: got %h want %h", b, a, b ? rdata_b : rdata_a, exp_d);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if ({ack_a, resp_a, err_a, ack_b, resp_b, err_b} !== 6'b0 || rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: a ack/resp/err=%b%b%b rdata=%h b ack/resp/err=%b%b%b rdata=%h, want all 0",
                     tag, ack_a, resp_a, err_a, rdata_a, ack_b, resp_b, err_b, rdata_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_write_read();
        do_txn(1'b0, 1'b1, 30'd5, 32'h1234_5678);
        do_txn(1'b0, 1'b0, 30'd5, 32'h0);
    endtask

    task automatic test_latency();
        do_txn(1'b1, 1'b1, 30'd0, 32'hA5A5_A5A5);
        do_txn(1'b1, 1'b0, 30'd0, 32'h0);
    endtask

    task automatic test_out_of_range();
        do_txn(1'b0, 1'b1, 30'd0, 32'h0BAD_F00D);
        do_txn(1'b0, 1'b1, 30'd256, 32'hFFFF_FFFF);
        do_txn(1'b0, 1'b0, 30'd0, 32'h0);
        do_txn(1'b0, 1'b0, 30'h3FFF_FFFF, 32'h0);
    endtask

    task automatic test_protocol_violation();
        int n_ack, n_resp, ack_at, resp_at;
        logic [31:0] exp_d, got_d;
        do_txn(1'b0, 1'b1, 30'd9, 32'h0000_0009);
        exp_d = exp_read(1'b0, 30'd5);
        n_ack = 0; n_resp = 0; ack_at = -1; resp_at = -1; got_d = '0;
        @(negedge clk);
        req_a = 1'b1; cmd = 1'b0; addr = 30'd5;
        @(negedge clk);
        cmd = 1'b1; addr = 30'd9; wdata = 32'hCAFE_0009;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            req_a = 1'b0;
            if (ack_a) begin n_ack++; ack_at = k; end
            if (resp_a) begin n_resp++; resp_at = k; got_d = rdata_a; end
            if (k == 1) begin
                n_checks++;
                if (err_a !== EXP_ERR) begin
                    n_fail++;
                    $display("FAIL err_set: got %b want %b", err_a, EXP_ERR);
                end
            end
        end
        n_checks++;
        if (n_ack !== 1 || ack_at !== 1 || n_resp !== 1 || resp_at !== 3) begin
            n_fail++;
            $display("FAIL viol_single_txn: acks=%0d@%0d resps=%0d@%0d, want 1@1 and 1@3",
                     n_ack, ack_at, n_resp, resp_at);
        end
        n_checks++;
        if (got_d !== exp_d) begin
            n_fail++;
            $display("FAIL viol_rdata: got %h want %h", got_d, exp_d);
        end
        n_checks++;
        if (err_a !== EXP_ERR || err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: a=%b b=%b, want a=%b b=0", err_a, err_b, EXP_ERR);
        end
        do_txn(1'b0, 1'b0, 30'd9, 32'h0);
    endtask

    task automatic test_reset_mid_op();
        int n_ack;
        do_txn(1'b1, 1'b1, 30'd7, 32'h7777_0007);
        n_ack = 0;
        @(negedge clk);
        req_b = 1'b1; cmd = 1'b1; addr = 30'd7; wdata = 32'h0000_00AA;
        @(negedge clk);
        req_b = 1'b0;
        if (ack_b) n_ack++;
        @(negedge clk);
        if (ack_b) n_ack++;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle_outputs("reset_mid_op");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack_b || resp_b) n_ack++;
        end
        n_checks++;
        if (n_ack !== 0) begin
            n_fail++;
            $display("FAIL aborted_no_ack: got %0d ack/resp pulses, want 0", n_ack);
        end
        do_txn(1'b1, 1'b0, 30'd7, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit          b;
            int          sel, idx;
            logic [29:0] a;
            b   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            idx = $urandom_range(0, 15);
            a   = {22'($urandom_range(1, 22'h3F_FFFF)), 8'($urandom)};
            case (sel)
                0: do_txn(b, 1'b1, 30'(idx), $urandom);
                1: do_txn(b, 1'b1, a, $urandom);
                2: if (wr_m[b][idx]) do_txn(b, 1'b0, 30'(idx), 32'h0);
                   else do_txn(b, 1'b1, 30'(idx), $urandom);
                default: do_txn(b, 1'b0, a, 32'h0);
            endcase
        end
    endtask

    task automatic test_back_to_back();
        bit          cmds [8];
        logic [29:0] adrs [8];
        logic [31:0] dats [8];
        int          start [8];
        int          exp_ack[$], exp_resp[$], got_ack[$], got_resp[$];
        logic [31:0] exp_rd[$], got_rd[$];
        int          s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            cmds[i] = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            adrs[i] = 30'($urandom_range(0, 1));
            if (i < 2) adrs[i] = 30'(i);
            dats[i] = $urandom;
            start[i] = s;
            exp_ack.push_back(s + 2);
            if (cmds[i]) begin
                model_write(1'b0, adrs[i], dats[i]);
                s += 2;
            end else begin
                exp_resp.push_back(s + 4);
                exp_rd.push_back(exp_read(1'b0, adrs[i]));
                s += 4;
            end
        end
        @(negedge clk);
        for (int n = 0; n <= s + 4; n++) begin
            if (ack_a) got_ack.push_back(n);
            if (resp_a) begin got_resp.push_back(n); got_rd.push_back(rdata_a); end
            req_a = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (start[i] == n) begin
                    req_a = 1'b1; cmd = cmds[i]; addr = adrs[i]; wdata = dats[i];
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (got_ack.size() != exp_ack.size() || got_resp.size() != exp_resp.size()) begin
            n_fail++;
            $display("FAIL b2b_counts: acks %0d resps %0d, want %0d and %0d",
                     got_ack.size(), got_resp.size(), exp_ack.size(), exp_resp.size());
        end else begin
            foreach (exp_ack[i]) begin
                n_checks++;
                if (got_ack[i] !== exp_ack[i]) begin
                    n_fail++;
                    $display("FAIL b2b_ack[%0d]: at %0d want %0d", i, got_ack[i], exp_ack[i]);
                end
            end
            foreach (exp_resp[i]) begin
                n_checks++;
                if (got_resp[i] !== exp_resp[i] || got_rd[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: at %0d data %h, want at %0d data %h",
                             i, got_resp[i], got_rd[i], exp_resp[i], exp_rd[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_out_of_range();
        test_protocol_violation();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
